reg_writeback_queue: RTL and testbench
======================================

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queued write entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of write data.
REQ-003 SHALL have ports clk (in, 1), the clock, and reset (in, 1); reset is synchronous, active-high; clock clk.
REQ-004 mem_valid  in  1  load-result write request (older producer).
REQ-005 mem_dest  in  5  destination register of load result.
REQ-006 mem_data  in  DATA_WIDTH  load result.
REQ-007 alu_valid  in  1  ALU-result write request (younger producer).
REQ-008 alu_dest  in  5  destination register of ALU result.
REQ-009 alu_data  in  DATA_WIDTH  ALU result.
REQ-010 mem_ready  out  1  mem request accepted this cycle when high.
REQ-011 alu_ready  out  1  alu request accepted this cycle when high.
REQ-012 wb_enable  in  1  register file may be written; low freezes draining.
REQ-013 canWrite  out  1  register-file write strobe (registered).
REQ-014 writeReg  out  5  register-file write address (registered).
REQ-015 writeData  out  DATA_WIDTH  register-file write data (registered).
REQ-016 query_rs, query_rt  in  5 each  source registers being read from the register file.
REQ-017 rs_pending, rt_pending  out  1 each  queried register has an unwritten value in the queue or output stage.
REQ-018 rs_fwd, rt_fwd  out  DATA_WIDTH each  youngest pending value for that register; 0 when not pending.
REQ-019 count  out  clog2(DEPTH)+1  occupied queue entries (output stage excluded).

Function
REQ-020 Queue SHALL be FIFO; one entry = {dest[4:0], data}.
REQ-021 Requests with dest 0 SHALL be accepted (ready high) but never enqueued; $0 is never written.
REQ-022 mem_ready SHALL equal (count < DEPTH); alu_ready SHALL equal (count + mem_take < DEPTH), mem_take = mem_valid & mem_ready & (mem_dest != 0); no credit for a same-cycle pop.
REQ-023 Same cycle both accepted: mem entry SHALL be enqueued ahead of the alu entry.
REQ-024 Pop: at posedge with wb_enable=1 and count>0, head SHALL move into output stage: canWrite=1, writeReg/writeData = head fields, count decrements (net of pushes).
REQ-025 At posedge with wb_enable=0 or count=0, canWrite SHALL become 0; writeReg/writeData hold previous values.
REQ-026 Latency: request accepted at edge k into empty queue with wb_enable=1 SHALL produce canWrite=1 in the cycle after edge k+1; sustained throughput one write per cycle.
REQ-027 Simultaneous push and pop SHALL both take effect; count = count + pushes - pop.
REQ-028 Pointers SHALL wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) distinguished by count, not pointer equality.
REQ-029 Pending lookup SHALL be combinational over valid queue entries plus the output stage when canWrite=1; queried register 0 SHALL never be pending.
REQ-030 Forward value SHALL come from the youngest match: newest queue entry first, then oldest, then output stage.
REQ-031 Requests presented with ready low SHALL be ignored; producer holds them.

Reset
REQ-032 reset at posedge SHALL empty the queue (count=0, pointers 0), clear canWrite, writeReg=0, writeData=0, regardless of in-flight requests or wb_enable.
REQ-033 During reset cycle, ready outputs SHALL reflect count before reset; any request accepted in that cycle SHALL be discarded.
REQ-034 Pending flags SHALL be 0 and fwd 0 in the cycle after reset.

Verification
REQ-035 Empty, wb_enable=1, alu_valid dest=5 data=0x12345678 at edge 1 -> canWrite=1, writeReg=5, writeData=0x12345678 after edge 2; then canWrite=0.
REQ-036 Same cycle mem dest=3 data=0xA, alu dest=3 data=0xB -> writes 3<-0xA then 3<-0xB on consecutive cycles; between, rs_fwd for query 3 = 0xB.
REQ-037 wb_enable=0, push 4 entries -> count=4, mem_ready=0, alu_ready=0; fifth request held; raise wb_enable -> 4 writes in order, held request accepted once count<4.
REQ-038 alu dest=0 data=0xFFFF -> alu_ready=1, count stays 0, canWrite never asserted, rs_pending for query 0 = 0.
REQ-039 Queue with 3 entries, pushes and pops continuous over 20 cycles crossing wrap point -> write order matches request order, count never exceeds 4.
REQ-040 reset asserted with count=3 and canWrite=1 -> next cycle count=0, canWrite=0, writeReg=0, all pending flags 0.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Register write-back bus: two write producers, register-file write port and
// the source-operand pending/forward lookup.
interface reg_writeback_queue_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) ();
    // Producers
    logic                    mem_valid;
    logic [4:0]              mem_dest;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic                    mem_ready;
    logic                    alu_valid;
    logic [4:0]              alu_dest;
    logic [DATA_WIDTH-1:0]   alu_data;
    logic                    alu_ready;
    // Register-file write port
    logic                    wb_enable;
    logic                    canWrite;
    logic [4:0]              writeReg;
    logic [DATA_WIDTH-1:0]   writeData;
    // Operand lookup
    logic [4:0]              query_rs;
    logic [4:0]              query_rt;
    logic                    rs_pending;
    logic                    rt_pending;
    logic [DATA_WIDTH-1:0]   rs_fwd;
    logic [DATA_WIDTH-1:0]   rt_fwd;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
        output wb_enable, query_rs, query_rt,
        input  mem_ready, alu_ready, canWrite, writeReg, writeData,
        input  rs_pending, rt_pending, rs_fwd, rt_fwd, count
    );

    modport slave (
        input  mem_valid, mem_dest, mem_data, alu_valid, alu_dest, alu_data,
        input  wb_enable, query_rs, query_rt,
        output mem_ready, alu_ready, canWrite, writeReg, writeData,
        output rs_pending, rt_pending, rs_fwd, rt_fwd, count
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Write-back queue: merges load and ALU results into one in-order register-file
// write stream, with a registered output stage and operand forwarding lookup.
module reg_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    reg_writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]            r_dest [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_can_write;
    logic [4:0]            r_write_reg;
    logic [DATA_WIDTH-1:0] r_write_data;

    logic                  w_mem_ready;
    logic                  w_alu_ready;
    logic                  w_mem_take;
    logic                  w_alu_take;
    logic                  w_pop;
    logic [PW-1:0]         w_alu_ptr;
    logic                  w_rs_pending;
    logic                  w_rt_pending;
    logic [DATA_WIDTH-1:0] w_rs_fwd;
    logic [DATA_WIDTH-1:0] w_rt_fwd;

    // Accept decisions; a same-cycle pop earns no credit. $0 writes are accepted, then dropped.
    assign w_mem_ready = (r_count < FULL);
    assign w_mem_take  = bus.mem_valid & w_mem_ready & (bus.mem_dest != 5'd0);
    assign w_alu_ready = ((r_count + CW'(w_mem_take)) < FULL);
    assign w_alu_take  = bus.alu_valid & w_alu_ready & (bus.alu_dest != 5'd0);
    assign w_pop       = bus.wb_enable & (r_count != '0);
    // The older (mem) producer lands first when both push together.
    assign w_alu_ptr   = r_wptr + PW'(w_mem_take);

    // Queue storage; entries beyond count are don't-care, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_mem_take) begin
            r_dest[r_wptr] <= bus.mem_dest;
            r_data[r_wptr] <= bus.mem_data;
        end
        if (w_alu_take) begin
            r_dest[w_alu_ptr] <= bus.alu_dest;
            r_data[w_alu_ptr] <= bus.alu_data;
        end
    end

    // Pointers, occupancy and the registered register-file write stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_can_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= '0;
        end else begin
            r_wptr      <= r_wptr + PW'(w_mem_take) + PW'(w_alu_take);
            r_rptr      <= r_rptr + PW'(w_pop);
            r_count     <= r_count + CW'(w_mem_take) + CW'(w_alu_take) - CW'(w_pop);
            r_can_write <= w_pop;
            if (w_pop) begin
                r_write_reg  <= r_dest[r_rptr];
                r_write_data <= r_data[r_rptr];
            end
        end
    end

    // Pending/forward lookup: output stage first, then queue oldest to newest so the
    // youngest match wins by overriding earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        w_rs_pending = 1'b0;
        w_rt_pending = 1'b0;
        w_rs_fwd     = '0;
        w_rt_fwd     = '0;
        idx          = '0;
        if (r_can_write) begin
            if (r_write_reg == bus.query_rs) begin
                w_rs_pending = 1'b1;
                w_rs_fwd     = r_write_data;
            end
            if (r_write_reg == bus.query_rt) begin
                w_rt_pending = 1'b1;
                w_rt_fwd     = r_write_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rptr + PW'(i);
            if (CW'(i) < r_count) begin
                if (r_dest[idx] == bus.query_rs) begin
                    w_rs_pending = 1'b1;
                    w_rs_fwd     = r_data[idx];
                end
                if (r_dest[idx] == bus.query_rt) begin
                    w_rt_pending = 1'b1;
                    w_rt_fwd     = r_data[idx];
                end
            end
        end
        if (bus.query_rs == 5'd0) begin
            w_rs_pending = 1'b0;
            w_rs_fwd     = '0;
        end
        if (bus.query_rt == 5'd0) begin
            w_rt_pending = 1'b0;
            w_rt_fwd     = '0;
        end
    end

    assign bus.mem_ready  = w_mem_ready;
    assign bus.alu_ready  = w_alu_ready;
    assign bus.canWrite   = r_can_write;
    assign bus.writeReg   = r_write_reg;
    assign bus.writeData  = r_write_data;
    assign bus.rs_pending = w_rs_pending;
    assign bus.rt_pending = w_rt_pending;
    assign bus.rs_fwd     = w_rs_fwd;
    assign bus.rt_fwd     = w_rt_fwd;
    assign bus.count      = r_count;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table plus hand-written
// sequences for back-pressure, wrap-around and reset.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_writeback_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdata;
        logic        av;
        logic [4:0]  ad;
        logic [31:0] adata;
        logic        wb;
        logic [4:0]  qrs;
        logic [4:0]  qrt;
        logic        mr;
        logic        ar;
        logic        rsp;
        logic [31:0] rsf;
        logic        rtp;
        logic [31:0] rtf;
        logic [2:0]  cnt;
        logic        cw;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[16];
    logic [36:0] got[$];
    logic [36:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic mv, input logic [4:0] md, input logic [31:0] mdata,
        input logic av, input logic [4:0] ad, input logic [31:0] adata,
        input logic wb, input logic [4:0] qrs, input logic [4:0] qrt,
        input logic mr, input logic ar, input logic rsp, input logic [31:0] rsf,
        input logic rtp, input logic [31:0] rtf, input logic [2:0] cnt,
        input logic cw, input logic [4:0] wr, input logic [31:0] wd);
        vec_t v;
        v.mv = mv; v.md = md; v.mdata = mdata; v.av = av; v.ad = ad; v.adata = adata;
        v.wb = wb; v.qrs = qrs; v.qrt = qrt; v.mr = mr; v.ar = ar; v.rsp = rsp;
        v.rsf = rsf; v.rtp = rtp; v.rtf = rtf; v.cnt = cnt; v.cw = cw; v.wr = wr;
        v.wd = wd;
        return v;
    endfunction

    task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                         input logic av, input logic [4:0] ad, input logic [31:0] adat);
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_data  = mdat;
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adat;
    endtask

    // Advance one clock and log any register-file write made at that edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.canWrite === 1'b1) got.push_back({bus.writeReg, bus.writeData});
    endtask

    task automatic cmp_writes(input string name);
        chk({name, "_nwrites"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_write%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt_m;
        int n;
        logic mv;
        logic mtake;
        logic mr_e;
        logic ar_e;
        logic accepted;

        // mv md mdata av ad adata wb qrs qrt | mr ar rsp rsf rtp rtf cnt cw wr wd
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 5, 32'h12345678, 1, 5, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 1, 1, 32'h12345678, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0,
                      1, 1, 1, 32'h12345678, 0, 0, 0, 1, 5, 32'h12345678);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 1, 0, 0, 0, 0, 0, 0, 5, 32'h12345678);
        vecs[5]  = mk(1, 3, 32'hA, 1, 3, 32'hB, 1, 3, 3,
                      1, 1, 0, 0, 0, 0, 0, 0, 5, 32'h12345678);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 3,
                      1, 1, 1, 32'hB, 1, 32'hB, 2, 0, 5, 32'h12345678);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 3,  1, 1, 1, 32'hB, 1, 32'hB, 1, 1, 3, 32'hA);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 3,  1, 1, 1, 32'hB, 1, 32'hB, 0, 1, 3, 32'hB);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 3,  1, 1, 0, 0, 0, 0, 0, 0, 3, 32'hB);
        vecs[10] = mk(0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3, 32'hB);
        vecs[11] = mk(1, 0, 32'h5, 1, 7, 32'h77, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 3, 32'hB);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 1, 32'h77, 0, 0, 1, 0, 3, 32'hB);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 7, 7,  1, 1, 1, 32'h77, 1, 32'h77, 1, 0, 3, 32'hB);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 1, 1, 32'h77, 0, 0, 0, 1, 7, 32'h77);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0,  1, 1, 0, 0, 0, 0, 0, 0, 7, 32'h77);

        reset = 1'b1;
        bus.wb_enable = 1'b1;
        bus.query_rs  = 5'd0;
        bus.query_rt  = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;

        // Directed vectors: check combinational and registered outputs, then clock.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].mv, vecs[i].md, vecs[i].mdata, vecs[i].av, vecs[i].ad, vecs[i].adata);
            bus.wb_enable = vecs[i].wb;
            bus.query_rs  = vecs[i].qrs;
            bus.query_rt  = vecs[i].qrt;
            #1;
            chk($sformatf("v%0d_mem_ready", i), 64'(bus.mem_ready), 64'(vecs[i].mr));
            chk($sformatf("v%0d_alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].ar));
            chk($sformatf("v%0d_rs_pending", i), 64'(bus.rs_pending), 64'(vecs[i].rsp));
            chk($sformatf("v%0d_rs_fwd", i), 64'(bus.rs_fwd), 64'(vecs[i].rsf));
            chk($sformatf("v%0d_rt_pending", i), 64'(bus.rt_pending), 64'(vecs[i].rtp));
            chk($sformatf("v%0d_rt_fwd", i), 64'(bus.rt_fwd), 64'(vecs[i].rtf));
            chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_canWrite", i), 64'(bus.canWrite), 64'(vecs[i].cw));
            chk($sformatf("v%0d_writeReg", i), 64'(bus.writeReg), 64'(vecs[i].wr));
            chk($sformatf("v%0d_writeData", i), 64'(bus.writeData), 64'(vecs[i].wd));
            step();
        end

        // Back-pressure: fill with draining frozen, hold a fifth request, then release.
        got.delete();
        exp_q.delete();
        bus.query_rs  = 5'd0;
        bus.query_rt  = 5'd0;
        bus.wb_enable = 1'b0;
        drive(1, 1, 32'h11, 1, 2, 32'h22);
        #1;
        chk("bp_fill1_ready", 64'({bus.mem_ready, bus.alu_ready}), 64'(2'b11));
        step();
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        #1;
        chk("bp_fill2_ready", 64'({bus.mem_ready, bus.alu_ready}), 64'(2'b11));
        step();
        drive(0, 0, 0, 1, 6, 32'h66);
        #1;
        chk("bp_full_count", 64'(bus.count), 64'(4));
        chk("bp_full_ready", 64'({bus.mem_ready, bus.alu_ready}), 64'(2'b00));
        step();
        chk("bp_held_count", 64'(bus.count), 64'(4));
        chk("bp_held_canWrite", 64'(bus.canWrite), 64'(0));
        bus.wb_enable = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 10 && !accepted; c++) begin
            #1;
            if (bus.alu_ready === 1'b1) begin
                chk("bp_accept_cycle", 64'(c), 64'(1));
                accepted = 1'b1;
            end
            step();
        end
        chk("bp_accepted", 64'(accepted), 64'(1));
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20 && got.size() < 5; c++) step();
        exp_q = '{{5'd1, 32'h11}, {5'd2, 32'h22}, {5'd3, 32'h33}, {5'd4, 32'h44},
                  {5'd6, 32'h66}};
        cmp_writes("bp");
        for (int c = 0; c < 3; c++) step();

        // Continuous push/pop across the pointer wrap, with a model of occupancy/readiness.
        got.delete();
        exp_q.delete();
        bus.wb_enable = 1'b0;
        drive(1, 10, 32'h100, 1, 11, 32'h101);
        step();
        drive(0, 0, 0, 1, 12, 32'h102);
        step();
        exp_q.push_back({5'd10, 32'h100});
        exp_q.push_back({5'd11, 32'h101});
        exp_q.push_back({5'd12, 32'h102});
        cnt_m = 3;
        #1;
        chk("wrap_prefill_count", 64'(bus.count), 64'(3));
        bus.wb_enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            logic [36:0] mi;
            logic [36:0] ai;
            mv = (i % 3 == 0);
            mi = {5'((n % 31) + 1), 32'hC000_0000 + 32'(n)};
            ai = {5'(((n + int'(mv)) % 31) + 1), 32'hC000_0000 + 32'(n + int'(mv))};
            drive(mv, mi[36:32], mi[31:0], 1'b1, ai[36:32], ai[31:0]);
            #1;
            mr_e  = (cnt_m < DEPTH);
            mtake = mv & mr_e;
            ar_e  = ((cnt_m + int'(mtake)) < DEPTH);
            chk($sformatf("wrap%0d_count", i), 64'(bus.count), 64'(cnt_m));
            chk($sformatf("wrap%0d_mem_ready", i), 64'(bus.mem_ready), 64'(mr_e));
            chk($sformatf("wrap%0d_alu_ready", i), 64'(bus.alu_ready), 64'(ar_e));
            if (mtake) exp_q.push_back(mi);
            if (ar_e) exp_q.push_back(ai);
            n = n + int'(mtake) + int'(ar_e);
            cnt_m = cnt_m + int'(mtake) + int'(ar_e) - ((cnt_m > 0) ? 1 : 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20 && got.size() < exp_q.size(); c++) step();
        cmp_writes("wrap");
        for (int c = 0; c < 3; c++) step();

        // Reset with a partly full queue and a live output stage.
        bus.wb_enable = 1'b0;
        drive(1, 21, 32'h21, 1, 22, 32'h22);
        step();
        drive(1, 23, 32'h23, 1, 24, 32'h24);
        step();
        drive(0, 0, 0, 0, 0, 0);
        bus.wb_enable = 1'b1;
        step();
        chk("rst_pre_count", 64'(bus.count), 64'(3));
        chk("rst_pre_canWrite", 64'(bus.canWrite), 64'(1));
        chk("rst_pre_writeReg", 64'(bus.writeReg), 64'(21));
        reset = 1'b1;
        drive(1, 9, 32'h99, 0, 0, 0);
        bus.query_rs = 5'd21;
        bus.query_rt = 5'd22;
        #1;
        chk("rst_cycle_mem_ready", 64'(bus.mem_ready), 64'(1));
        chk("rst_cycle_rs_pending", 64'(bus.rs_pending), 64'(1));
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        bus.query_rt = 5'd9;
        #1;
        chk("rst_post_count", 64'(bus.count), 64'(0));
        chk("rst_post_canWrite", 64'(bus.canWrite), 64'(0));
        chk("rst_post_writeReg", 64'(bus.writeReg), 64'(0));
        chk("rst_post_writeData", 64'(bus.writeData), 64'(0));
        chk("rst_post_rs_pending", 64'(bus.rs_pending), 64'(0));
        chk("rst_post_rt_pending", 64'(bus.rt_pending), 64'(0));
        chk("rst_post_rs_fwd", 64'(bus.rs_fwd), 64'(0));
        step();
        chk("rst_after_count", 64'(bus.count), 64'(0));
        chk("rst_after_canWrite", 64'(bus.canWrite), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
